// File: rtl/base_rotl_dec_pipe.sv
// -----------------------------------------------------------------------------
// base_rotl_dec_pipe
//
// Receive-side inverse of the lane rotate-right encoder. A beat of `ways`
// lanes arrives rotated right by i_sel. The block rotates it left by the same
// amount, which restores the original lane order. The result is then
// registered behind a valid/ready handshake.
//
// A main output register (M) and a skid register (S) let the block hold full
// throughput under backpressure. i_r is driven straight from the skid-valid
// flop, so no combinational path runs from o_r to i_r.
//
// If a beat is accepted with a rotate amount >= ways, it is still forwarded,
// but with every lane forced to zero. That beat also sets the sticky o_err
// flag. This case can only arise when ways is not a power of two.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   i_v    - input beat valid
//   i_r    - input ready (registered: ~skid valid)
//   i_d    - rotated beat, lane j = i_d[(j+1)*width-1 : j*width]
//   i_sel  - rotate amount applied by the encoder, unsigned, i_sel[0] is MSB
//   o_v    - output beat valid
//   o_r    - output ready
//   o_d    - restored beat
//   o_err  - sticky illegal-rotate flag
// -----------------------------------------------------------------------------
module base_rotl_dec_pipe #(
    parameter int width     = 1,
    parameter int ways      = 1,
    parameter int sel_width = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [ways*width-1:0]  i_d,
    input  logic [0:sel_width-1]   i_sel,
    output logic                   o_v,
    input  logic                   o_r,
    output logic [ways*width-1:0]  o_d,
    output logic                   o_err
);

    localparam int W = ways * width;

    logic [31:0]  w_sel_u;
    logic         w_illegal;
    logic [W-1:0] w_rot;
    logic [W-1:0] w_beat;
    logic         w_acc;

    logic         r_m_v;
    logic [W-1:0] r_m_d;
    logic         r_s_v;
    logic [W-1:0] r_s_d;
    logic         r_err;

    assign w_sel_u   = 32'(i_sel);
    // A single lane cannot be rotated, so the amount is never illegal there.
    assign w_illegal = (ways > 1) && (w_sel_u >= 32'(ways));

    // Rotate left: out lane k takes in lane (k - sel) mod ways. Each possible
    // amount is expanded with constant lane indices, so the result is a plain
    // mux. An illegal amount matches no branch, and the lanes stay zero.
    always_comb begin
        w_rot = '0;
        if (ways == 1) begin
            w_rot = i_d;
        end else begin
            for (int s = 0; s < ways; s++) begin
                if (w_sel_u == 32'(s)) begin
                    for (int k = 0; k < ways; k++) begin
                        w_rot[k*width +: width] = i_d[((k + ways - s) % ways)*width +: width];
                    end
                end
            end
        end
    end

    assign w_beat = w_illegal ? '0 : w_rot;
    assign w_acc  = i_v & i_r;

    // S can only hold a beat while M is full. This means that:
    // - with S full, no beat is accepted, and a drain shifts S into M;
    // - with S empty, an accepted beat goes to M whenever M is empty or
    //   draining on this edge, and goes to S otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_v <= 1'b0;
            r_m_d <= '0;
            r_s_v <= 1'b0;
            r_s_d <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_acc && w_illegal) begin
                r_err <= 1'b1;
            end
            if (r_s_v) begin
                if (o_r) begin
                    r_m_d <= r_s_d;
                    r_s_v <= 1'b0;
                end
            end else if (w_acc) begin
                if (!r_m_v || o_r) begin
                    r_m_v <= 1'b1;
                    r_m_d <= w_beat;
                end else begin
                    r_s_v <= 1'b1;
                    r_s_d <= w_beat;
                end
            end else if (o_r) begin
                r_m_v <= 1'b0;
            end
        end
    end

    assign i_r   = ~r_s_v;
    assign o_v   = r_m_v;
    assign o_d   = r_m_d;
    assign o_err = r_err;

endmodule

// File: tb/tb_base_rotl_dec_pipe.sv
module tb_base_rotl_dec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // four-lane byte instance
    logic        a_iv, a_ir, a_ov, a_or, a_err;
    logic [31:0] a_id, a_od, a_exp;
    logic [0:1]  a_sel;

    // three-lane nibble instance
    logic        b_iv, b_ir, b_ov, b_or, b_err;
    logic [11:0] b_id, b_od;
    logic [0:1]  b_sel;

    int checks = 0;
    int errors = 0;

    logic        mon_en = 1'b0;
    logic [31:0] q[$];
    logic        r_stall = 1'b0;
    logic [31:0] r_stall_d = '0;

    base_rotl_dec_pipe #(.width(8), .ways(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_v(a_iv), .i_r(a_ir), .i_d(a_id), .i_sel(a_sel),
        .o_v(a_ov), .o_r(a_or), .o_d(a_od), .o_err(a_err)
    );

    base_rotl_dec_pipe #(.width(4), .ways(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_v(b_iv), .i_r(b_ir), .i_d(b_id), .i_sel(b_sel),
        .o_v(b_ov), .o_r(b_or), .o_d(b_od), .o_err(b_err)
    );

    // encoder model: enc lane i = orig lane (i+sel) mod ways
    function automatic logic [31:0] enc4(input logic [31:0] d, input int s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = d[((i + s) % 4)*8 +: 8];
        return r;
    endfunction

    function automatic logic [11:0] enc3(input logic [11:0] d, input int s);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) r[i*4 +: 4] = d[((i + s) % 3)*4 +: 4];
        return r;
    endfunction

    // Scoreboard on the four-lane instance: the original (pre-encoder) beat is
    // queued on input transfer and compared on output transfer. Queue depth
    // equals M+S occupancy, so o_v and i_r are also checked against it.
    always @(posedge clk) begin
        if (mon_en && rst_n) begin
            checks++;
            if (a_ov !== (q.size() != 0)) begin
                errors++;
                $display("FAIL ov_vs_occupancy: o_v=%b occupancy=%0d", a_ov, q.size());
            end
            checks++;
            if (a_ir !== (q.size() < 2)) begin
                errors++;
                $display("FAIL ir_vs_skid: i_r=%b occupancy=%0d", a_ir, q.size());
            end
            if (r_stall) begin
                checks++;
                if (a_ov !== 1'b1 || a_od !== r_stall_d) begin
                    errors++;
                    $display("FAIL stall_stable: o_v=%b o_d=%h required o_v=1 o_d=%h", a_ov, a_od, r_stall_d);
                end
            end
            if (a_ov && a_or) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: o_d=%h with no expected beat", a_od);
                end else begin
                    logic [31:0] e;
                    e = q.pop_front();
                    if (a_od !== e) begin
                        errors++;
                        $display("FAIL sb_data: o_d=%h required %h", a_od, e);
                    end
                end
            end
            if (a_iv && a_ir) q.push_back(a_exp);
            r_stall   = a_ov && !a_or;
            r_stall_d = a_od;
        end else begin
            q.delete();
            r_stall = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b1;
        a_iv = 0; a_or = 0; a_id = '0; a_sel = '0; a_exp = '0;
        b_iv = 0; b_or = 0; b_id = '0; b_sel = '0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_err !== 1'b0 || a_od !== 32'h0) begin
            errors++;
            $display("FAIL reset4: o_v=%b i_r=%b o_err=%b o_d=%h required 0 1 0 0", a_ov, a_ir, a_err, a_od);
        end
        checks++;
        if (b_ov !== 1'b0 || b_ir !== 1'b1 || b_err !== 1'b0 || b_od !== 12'h0) begin
            errors++;
            $display("FAIL reset3: o_v=%b i_r=%b o_err=%b o_d=%h required 0 1 0 0", b_ov, b_ir, b_err, b_od);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        @(negedge clk);
        a_or = 1; a_iv = 1; a_sel = 2'd1; a_id = 32'h00332211; a_exp = 32'h33221100;
        #1;
        checks++;
        if (a_ov !== 1'b0) begin
            errors++;
            $display("FAIL basic_pre: o_v=%b required 0", a_ov);
        end
        @(negedge clk);
        a_iv = 0;
        checks++;
        if (a_ov !== 1'b1 || a_od !== 32'h33221100 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL basic: o_v=%b o_d=%h o_err=%b required 1 33221100 0", a_ov, a_od, a_err);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        a_or = 1;
        for (int s = 0; s < 4; s++) begin
            a_iv = 1; a_sel = 2'(s); a_id = enc4(32'h33221100, s); a_exp = 32'h33221100;
            #1;
            checks++;
            if (a_ir !== 1'b1) begin
                errors++;
                $display("FAIL sweep_ready: sel=%0d i_r=%b required 1", s, a_ir);
            end
            @(negedge clk);
            checks++;
            if (a_ov !== 1'b1 || a_od !== 32'h33221100) begin
                errors++;
                $display("FAIL sweep: sel=%0d o_v=%b o_d=%h required 1 33221100", s, a_ov, a_od);
            end
        end
        a_iv = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int n;
        int cyc;
        logic acc;
        logic [31:0] orig;
        n = 0; cyc = 0;
        while ((n < 6 || q.size() != 0) && cyc < 40) begin
            a_or = !(cyc >= 2 && cyc < 5);
            if (n < 6) begin
                orig = 32'h33221100 | 32'(n);
                a_iv = 1; a_sel = 2'(n % 4); a_id = enc4(orig, n % 4); a_exp = orig;
            end else begin
                a_iv = 0;
            end
            #1;
            if (cyc == 2 || cyc == 3 || cyc == 5 || cyc == 6) begin
                logic req;
                req = (cyc == 2 || cyc == 6);
                checks++;
                if (a_ir !== req) begin
                    errors++;
                    $display("FAIL bp_ready: cycle=%0d i_r=%b required %b", cyc, a_ir, req);
                end
            end
            acc = a_iv && a_ir;
            @(negedge clk);
            if (acc) n++;
            cyc++;
        end
        a_iv = 0; a_or = 1;
        checks++;
        if (n != 6 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_done: accepted=%0d pending=%0d required 6 0", n, q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        b_or = 1;
        checks++;
        if (b_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pre: o_err=%b required 0", b_err);
        end
        b_iv = 1; b_sel = 2'd3; b_id = 12'h321;
        @(negedge clk);
        checks++;
        if (b_ov !== 1'b1 || b_od !== 12'h000 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal: o_v=%b o_d=%h o_err=%b required 1 000 1", b_ov, b_od, b_err);
        end
        for (int s = 0; s < 3; s++) begin
            b_iv = 1; b_sel = 2'(s); b_id = enc3(12'h321, s);
            @(negedge clk);
            checks++;
            if (b_ov !== 1'b1 || b_od !== 12'h321 || b_err !== 1'b1) begin
                errors++;
                $display("FAIL illegal_sticky: sel=%0d o_v=%b o_d=%h o_err=%b required 1 321 1", s, b_ov, b_od, b_err);
            end
        end
        b_iv = 0;
        @(negedge clk);
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL err4_clear: o_err=%b required 0", a_err);
        end
    endtask

    task automatic test_reset_mid;
        a_or = 0; a_iv = 1; a_sel = 2'd0; a_id = 32'hA3A2A1A0; a_exp = 32'hA3A2A1A0;
        @(negedge clk);
        a_id = 32'hB3B2B1B0; a_exp = 32'hB3B2B1B0;
        @(negedge clk);
        a_iv = 0;
        #1;
        checks++;
        if (a_ov !== 1'b1 || a_ir !== 1'b0 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL full_pre: o_v=%b i_r=%b err3=%b required 1 0 1", a_ov, a_ir, b_err);
        end
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_od !== 32'h0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: o_v=%b i_r=%b o_d=%h err3=%b required 0 1 0 0", a_ov, a_ir, a_od, b_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        a_or = 1; a_iv = 1; a_sel = 2'd2; a_id = 32'h11003322; a_exp = 32'h33221100;
        @(negedge clk);
        a_iv = 0;
        checks++;
        if (a_ov !== 1'b1 || a_od !== 32'h33221100) begin
            errors++;
            $display("FAIL post_reset: o_v=%b o_d=%h required 1 33221100", a_ov, a_od);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int n;
        int cyc;
        logic acc;
        logic [31:0] orig;
        int s;
        n = 0; cyc = 0;
        orig = $urandom; s = $urandom_range(0, 3);
        while (n < 10000 && cyc < 60000) begin
            a_iv = ($urandom_range(0, 3) != 0);
            a_or = ($urandom_range(0, 2) != 0);
            a_sel = 2'(s); a_id = enc4(orig, s); a_exp = orig;
            #1;
            acc = a_iv && a_ir;
            @(negedge clk);
            if (acc) begin
                n++;
                orig = $urandom; s = $urandom_range(0, 3);
            end
            cyc++;
        end
        a_iv = 0; a_or = 1;
        repeat (4) @(negedge clk);
        checks++;
        if (n != 10000 || q.size() != 0) begin
            errors++;
            $display("FAIL random_done: accepted=%0d pending=%0d required 10000 0", n, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
